// File: rtl/mips_datapath_pc_fetch_pkg.sv
// Shared definitions for the PC / fetch-request stage: action encoding,
// fetch state constants and the reset vector.
package mips_datapath_pc_fetch_pkg;

    // PC action resolved in EX (existing datapath encoding)
    typedef enum logic [1:0] {
        ACT_INC      = 2'd0,
        ACT_BRANCH   = 2'd1,
        ACT_JUMP     = 2'd2,
        ACT_REGISTER = 2'd3
    } pc_action_t;

    // Fetch state: RUN fetches normally, PENDING waits to apply a latched redirect
    localparam int unsigned  STATE_W    = 1;
    localparam logic [0:0]   ST_RUN     = 1'b0;
    localparam logic [0:0]   ST_PENDING = 1'b1;

    localparam logic [31:0]  RESET_VECTOR = 32'h0040_0000;

endpackage

// File: rtl/mips_datapath_pc_fetch_target.sv
// Combinational redirect-target mux for Branch / Jump / Register actions.
// Kept separate so a future branch-prediction check can reuse it.
module mips_datapath_pc_fetch_target
    import mips_datapath_pc_fetch_pkg::*;
(
    input  logic [1:0]  action,
    input  logic [31:0] ex_pc_inc,
    input  logic [31:0] ex_offset,
    input  logic [25:0] ex_target,
    input  logic [31:0] ex_register,
    output logic [31:0] target
);

    // Select the redirect address; Inc has no target, PC+4 is a harmless default
    always_comb begin
        target = ex_pc_inc;
        case (action)
            ACT_BRANCH:   target = ex_pc_inc + {ex_offset[29:0], 2'b00};
            ACT_JUMP:     target = {ex_pc_inc[31:28], ex_target, 2'b00};
            ACT_REGISTER: target = ex_register;
            default:      target = ex_pc_inc;
        endcase
    end

endmodule

// File: rtl/mips_datapath_pc_fetch.sv
// PC register and fetch-request stage. Holds the fetch address across
// instruction-memory wait states and latches a redirect that arrives while
// a fetch is outstanding, applying it once memory completes.
module mips_datapath_pc_fetch
    import mips_datapath_pc_fetch_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  action,
    input  logic [31:0] ex_pc_inc,
    input  logic [31:0] ex_offset,
    input  logic [25:0] ex_target,
    input  logic [31:0] ex_register,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic [31:0] pc_inc,
    output logic        flush
);

    logic [STATE_W-1:0] state;
    logic [31:0]        pending;
    logic [31:0]        target;
    logic               redirect;

    mips_datapath_pc_fetch_target u_target (
        .action      (action),
        .ex_pc_inc   (ex_pc_inc),
        .ex_offset   (ex_offset),
        .ex_target   (ex_target),
        .ex_register (ex_register),
        .target      (target)
    );

    // Redirect request, fetch handshake and squash of younger stages
    always_comb begin
        redirect = (action != ACT_INC);
        pc_valid = !reset;
        pc_inc   = pc + 32'd4;
        flush    = !reset && (redirect || ((state == ST_PENDING) && imem_ready));
    end

    // PC / pending-target update; pc only moves on an accepted fetch or reset
    always_ff @(posedge clock) begin
        if (reset) begin
            pc      <= RESET_VECTOR;
            state   <= ST_RUN;
            pending <= 32'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc <= target;
                        end else begin
                            pending <= target;
                            state   <= ST_PENDING;
                        end
                    end else if (!stall && imem_ready) begin
                        pc <= pc + 32'd4;
                    end
                end
                ST_PENDING: begin
                    if (imem_ready) begin
                        pc    <= redirect ? target : pending;
                        state <= ST_RUN;
                    end else if (redirect) begin
                        pending <= target;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_datapath_pc_fetch.sv
// Scoreboard testbench for mips_datapath_pc_fetch: directed scenarios followed
// by randomized traffic, checked against a behavioural fetch model.
module tb_mips_datapath_pc_fetch;

    localparam logic [31:0] RV = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  action;
    logic [31:0] ex_pc_inc;
    logic [31:0] ex_offset;
    logic [25:0] ex_target;
    logic [31:0] ex_register;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc;
    logic        pc_valid;
    logic [31:0] pc_inc;
    logic        flush;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc_inc;
        logic        pc_valid;
        logic        flush;
        bit          pc_known;
    } expect_t;

    expect_t exp_q[$];

    int  check_count = 0;
    int  pass_count  = 0;
    bit  stim_done   = 0;

    // Behavioural model: current PC, whether a redirect is waiting, and its address
    logic [31:0] m_pc;
    bit          m_known       = 0;
    bit          m_has_pending = 0;
    logic [31:0] m_pending     = 32'd0;

    mips_datapath_pc_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .action      (action),
        .ex_pc_inc   (ex_pc_inc),
        .ex_offset   (ex_offset),
        .ex_target   (ex_target),
        .ex_register (ex_register),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .pc_inc      (pc_inc),
        .flush       (flush)
    );

    always #5 clock = ~clock;

    // Redirect address as described by the action: branch offset counts words
    function automatic logic [31:0] model_target(input logic [1:0] act, input logic [31:0] pinc,
                                                 input logic [31:0] off, input logic [25:0] tgt,
                                                 input logic [31:0] rs);
        logic [31:0] t;
        t = pinc;
        if (act == 2'd1) t = pinc + off * 32'd4;
        if (act == 2'd2) t = (pinc & 32'hF000_0000) | ({6'd0, tgt} * 32'd4);
        if (act == 2'd3) t = rs;
        return t;
    endfunction

    // Drive one cycle of inputs, push the expected outputs, advance the model
    task automatic applyStimulus(input logic rst, input logic [1:0] act, input logic [31:0] pinc,
                                 input logic [31:0] off, input logic [25:0] tgt,
                                 input logic [31:0] rs, input logic stl, input logic rdy);
        expect_t     e;
        logic [31:0] t;
        bit          redir;
        @(posedge clock);
        #1;
        reset       = rst;
        action      = act;
        ex_pc_inc   = pinc;
        ex_offset   = off;
        ex_target   = tgt;
        ex_register = rs;
        stall       = stl;
        imem_ready  = rdy;

        redir = (act != 2'd0);
        t     = model_target(act, pinc, off, tgt, rs);

        e.pc       = m_pc;
        e.pc_inc   = m_pc + 32'd4;
        e.pc_valid = !rst;
        e.flush    = !rst && (redir || (m_has_pending && rdy));
        e.pc_known = m_known;
        exp_q.push_back(e);

        if (rst) begin
            m_pc          = RV;
            m_known       = 1;
            m_has_pending = 0;
            m_pending     = 32'd0;
        end else if (m_has_pending) begin
            if (rdy) begin
                m_pc          = redir ? t : m_pending;
                m_has_pending = 0;
            end else if (redir) begin
                m_pending = t;
            end
        end else if (redir) begin
            if (rdy) m_pc = t;
            else begin
                m_has_pending = 1;
                m_pending     = t;
            end
        end else if (rdy && !stl) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    endtask

    // Monitor: every cycle the DUT presents outputs, pop and compare
    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("pc_valid", {31'd0, pc_valid}, {31'd0, e.pc_valid});
                checkOutput("flush", {31'd0, flush}, {31'd0, e.flush});
                if (e.pc_known) begin
                    checkOutput("pc", pc, e.pc);
                    checkOutput("pc_inc", pc_inc, e.pc_inc);
                end
            end
        end
    end

    // Stimulus: directed scenarios, then random traffic
    initial begin
        reset       = 1'b1;
        action      = 2'd0;
        ex_pc_inc   = 32'd0;
        ex_offset   = 32'd0;
        ex_target   = 26'd0;
        ex_register = 32'd0;
        stall       = 1'b0;
        imem_ready  = 1'b0;

        // reset, then sequential fetch from the reset vector
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // branch back by two words from 0x00400008
        applyStimulus(0, 1, 32'h0040_0008, 32'hFFFF_FFFE, 0, 0, 0, 1);
        // jump while memory waits three cycles
        applyStimulus(0, 2, 32'hA000_0000, 0, 26'h000_0100, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // stall, then a register redirect that overrides the stall
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 3, 0, 0, 0, 32'h0040_0100, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // two redirects while pending: newer wins
        applyStimulus(0, 3, 0, 0, 0, 32'h0000_1000, 0, 0);
        applyStimulus(0, 3, 0, 0, 0, 32'h0000_2000, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        // reset while pending discards the pending target
        applyStimulus(0, 3, 0, 0, 0, 32'h0000_3000, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        // wrap from the top of the address space
        applyStimulus(0, 3, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic       rst;
            logic [1:0] act;
            rst = ($urandom_range(0, 49) == 0);
            act = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            applyStimulus(rst, act, $urandom, $urandom, 26'($urandom), $urandom,
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7));
        end
        stim_done = 1;
    end

    // Drain the scoreboard with a bounded wait, then report
    initial begin
        wait (stim_done);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        @(negedge clock);
        if (exp_q.size() > 0) begin
            check_count++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mips_datapath_pc_fetch.md
# mips_datapath_pc_fetch

Program-counter register and fetch-request stage of the pipelined datapath, directly downstream of the PC action resolver. It consumes the resolved PC action from the EX stage and computes the redirect target. It holds the fetch address stable across instruction-memory wait states, and latches a redirect that arrives while a fetch is still outstanding. It drives the fetch address to instruction memory, PC+4 to the IF/ID register, and the squash signal to IF/ID and ID/EX.

## Interface
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- action  input  2  resolved PC action from EX; existing encoding Inc, Branch, Jump, Register
- ex_pc_inc  input  32  PC+4 of the EX-stage instruction
- ex_offset  input  32  sign-extended branch immediate (word offset)
- ex_target  input  26  J-format index
- ex_register  input  32  rs operand for Register action
- stall  input  1  hazard unit: hold fetch
- imem_ready  input  1  instruction memory accepts/completes current address this cycle
- pc  output  32  fetch address
- pc_valid  output  1  fetch request
- pc_inc  output  32  pc + 4, to IF/ID
- flush  output  1  squash IF/ID and ID/EX this cycle

## Operation
- Redirect = action ≠ Inc. Target by action:
  - Branch: ex_pc_inc + (ex_offset << 2), mod 2^32.
  - Jump: {ex_pc_inc[31:28], ex_target, 2'b00}.
  - Register: ex_register unchanged; no alignment check.
- pc_inc = pc + 4 mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- Fetch handshake: pc_valid=1 in every non-reset cycle. The address is accepted when pc_valid & imem_ready. pc must not change while pc_valid & !imem_ready, except under reset.
- States:
  - RUN:
    - redirect & imem_ready: pc ← target, stay RUN.
    - redirect & !imem_ready: pending ← target, go PENDING.
    - no redirect & !stall & imem_ready: pc ← pc+4.
    - otherwise: hold.
  - PENDING:
    - Hold pc until imem_ready. On that cycle pc ← pending, go RUN.
    - A new redirect while in PENDING overwrites pending; the newer target wins.
    - stall is ignored.
- Priority: reset > redirect > stall > sequential increment. A redirect overrides stall because the stalled younger instructions are squashed.
- flush (combinational) = !reset & (redirect | (state==PENDING & imem_ready)). The second term discards the stale word returned for the pre-redirect address.

## Timing
- Reset values: pc=RESET_VECTOR, pc_valid=0, flush=0, state RUN, pending=0. pc_valid rises in the first cycle after reset deasserts.
- Reset in PENDING: pending is discarded and the PC restarts at RESET_VECTOR.
- Redirect at cycle N with imem_ready=1: flush=1 at N, pc=target at N+1.
- Redirect at N with imem_ready=0: flush=1 at N, pc held. At the first cycle M>N with imem_ready=1, flush=1 and pc=target at M+1.
- Sequential fetch: one increment per accepted cycle. Zero-wait memory gives 1 fetch/cycle.
- stall & !redirect: pc and pc_inc are held. The cycle stall falls, pc advances if imem_ready.
- No combinational path from imem_ready to pc. flush depends combinationally on action and imem_ready.

## Structure
- Shared header Mips/Datapath/Pc/State.v: state width, RUN/PENDING constants, `_T` type macro.
- Reuse the existing PC action encoding header; no new action values.
- One sub-module, Mips_Datapath_Pc_target: combinational target mux (Branch/Jump/Register). It is reused by any future branch-prediction check.

## Test plan
- Reset, then imem_ready=1 for 4 cycles: pc = 0x00400000, 0x00400004, 0x00400008, 0x0040000C; pc_valid 0 during reset, then 1.
- At pc=0x00400010, action=Branch, ex_pc_inc=0x00400008, ex_offset=-2, imem_ready=1: flush=1 that cycle, next pc=0x00400000.
- Jump with ex_pc_inc=0xA0000000, ex_target=26'h0000100 while imem_ready=0 for 3 cycles:
  - pc held and flush=1 on the redirect cycle.
  - flush=1 again on the ready cycle.
  - pc=0xA0000400 the cycle after.
- stall=1 for 2 cycles with action=Register, ex_register=0x00400100 in the second: pc=0x00400100 next cycle, flush=1.
- Two redirects while PENDING (targets 0x1000, then 0x2000): after imem_ready, pc=0x2000.
- reset asserted while PENDING: pc=0x00400000, flush=0. Then pc=0xFFFFFFFC with imem_ready=1 wraps pc to 0x00000000.
